// File: rtl/program_loader.sv
// Boot sequencer: streams a program into instruction memory, holds the core
// in reset while loading, then releases it and counts run cycles until halt.
// Ports: clock/reset; start; in_data/in_valid/in_last/in_ready stream;
//  im_we/im_addr/im_wdata memory write; core_reset; halt; busy/done status;
//  words_loaded, cycle_count, cycle_ovf results.
module program_loader #(
  parameter int PC_BITS    = 9,
  parameter int INSTR_BITS = 9,
  parameter int CYCLE_BITS = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [INSTR_BITS-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  im_we,
  output logic [PC_BITS-1:0]    im_addr,
  output logic [INSTR_BITS-1:0] im_wdata,
  output logic                  core_reset,
  input  logic                  halt,
  output logic                  busy,
  output logic                  done,
  output logic [PC_BITS:0]      words_loaded,
  output logic [CYCLE_BITS-1:0] cycle_count,
  output logic                  cycle_ovf
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [PC_BITS-1:0]    ADDR_MAX = '1;
  localparam logic [PC_BITS-1:0]    ADDR_ONE = PC_BITS'(1);
  localparam logic [PC_BITS:0]      WORD_ONE = (PC_BITS+1)'(1);
  localparam logic [CYCLE_BITS-1:0] CNT_MAX  = '1;
  localparam logic [CYCLE_BITS-1:0] CNT_ONE  = CYCLE_BITS'(1);

  logic [2:0]            state_q, state_d;
  logic [PC_BITS-1:0]    load_addr_q, load_addr_d;
  logic [PC_BITS:0]      words_q, words_d;
  logic [CYCLE_BITS-1:0] cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  im_we_q, im_we_d;
  logic [PC_BITS-1:0]    im_addr_q, im_addr_d;
  logic [INSTR_BITS-1:0] im_wdata_q, im_wdata_d;
  logic                  core_reset_q, core_reset_d;
  logic                  accept;

  assign in_ready = (state_q == S_LOAD);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    words_d     = words_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    im_we_d     = 1'b0;
    im_addr_d   = im_addr_q;
    im_wdata_d  = im_wdata_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_LOAD;
          load_addr_d = '0;
          words_d     = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          im_we_d     = 1'b1;
          im_addr_d   = load_addr_q;
          im_wdata_d  = in_data;
          load_addr_d = load_addr_q + ADDR_ONE;
          words_d     = words_q + WORD_ONE;
          // Full memory ends the load without wrapping.
          if (in_last || load_addr_q == ADDR_MAX)
            state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_RUN;
      S_RUN: begin
        if (halt)
          state_d = S_DONE;
        else if (cnt_q == CNT_MAX)
          ovf_d = 1'b1;
        else
          cnt_d = cnt_q + CNT_ONE;
      end
      default: state_d = S_IDLE;
    endcase
    // Registered so the core sees reset low from the first RUN cycle.
    core_reset_d = (state_d != S_RUN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      load_addr_q  <= '0;
      words_q      <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      im_we_q      <= 1'b0;
      im_addr_q    <= '0;
      im_wdata_q   <= '0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      load_addr_q  <= load_addr_d;
      words_q      <= words_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
      core_reset_q <= core_reset_d;
    end
  end

  assign im_we        = im_we_q;
  assign im_addr      = im_addr_q;
  assign im_wdata     = im_wdata_q;
  assign core_reset   = core_reset_q;
  assign busy         = (state_q == S_LOAD) || (state_q == S_FLUSH)
                        || (state_q == S_RUN);
  assign done         = (state_q == S_DONE);
  assign words_loaded = words_q;
  assign cycle_count  = cnt_q;
  assign cycle_ovf    = ovf_q;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: random programs and run lengths checked
// against a program-list / saturating-count reference model.
module tb_program_loader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, start, in_valid, in_last, halt;
  logic [8:0]  in_data;
  logic        in_ready, im_we, core_reset, busy, done, cycle_ovf;
  logic [8:0]  im_addr, im_wdata;
  logic [9:0]  words_loaded;
  logic [15:0] cycle_count;

  logic        s_reset, s_start, s_in_valid, s_in_last, s_halt;
  logic [8:0]  s_in_data;
  logic        s_in_ready, s_im_we, s_core_reset, s_busy, s_done, s_cycle_ovf;
  logic [2:0]  s_im_addr;
  logic [8:0]  s_im_wdata;
  logic [3:0]  s_words_loaded;
  logic [3:0]  s_cycle_count;

  program_loader #(.PC_BITS(9), .INSTR_BITS(9), .CYCLE_BITS(16)) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .core_reset(core_reset), .halt(halt),
    .busy(busy), .done(done), .words_loaded(words_loaded),
    .cycle_count(cycle_count), .cycle_ovf(cycle_ovf)
  );

  program_loader #(.PC_BITS(3), .INSTR_BITS(9), .CYCLE_BITS(4)) dut_s (
    .clock(clock), .reset(s_reset), .start(s_start),
    .in_data(s_in_data), .in_valid(s_in_valid), .in_last(s_in_last),
    .in_ready(s_in_ready), .im_we(s_im_we), .im_addr(s_im_addr),
    .im_wdata(s_im_wdata), .core_reset(s_core_reset), .halt(s_halt),
    .busy(s_busy), .done(s_done), .words_loaded(s_words_loaded),
    .cycle_count(s_cycle_count), .cycle_ovf(s_cycle_ovf)
  );

  int total  = 0;
  int passes = 0;

  logic [8:0]  prog[$];
  logic [17:0] cap[$];
  logic [11:0] s_cap[$];

  always @(negedge clock) begin
    if (im_we === 1'b1)   cap.push_back({im_addr, im_wdata});
    if (s_im_we === 1'b1) s_cap.push_back({s_im_addr, s_im_wdata});
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    // Intentionally unused wrapper avoided: checks are inline below.
  endtask

  task automatic check_idle_values(input string tag);
    total++; if (in_ready !== 1'b0) $display("FAIL %s in_ready got=%0h exp=0", tag, in_ready); else passes++;
    total++; if (im_we !== 1'b0) $display("FAIL %s im_we got=%0h exp=0", tag, im_we); else passes++;
    total++; if (im_addr !== 9'd0) $display("FAIL %s im_addr got=%0h exp=0", tag, im_addr); else passes++;
    total++; if (im_wdata !== 9'd0) $display("FAIL %s im_wdata got=%0h exp=0", tag, im_wdata); else passes++;
    total++; if (core_reset !== 1'b1) $display("FAIL %s core_reset got=%0h exp=1", tag, core_reset); else passes++;
    total++; if ({busy, done} !== 2'b00) $display("FAIL %s busy_done got=%0h exp=0", tag, {busy, done}); else passes++;
    total++; if (words_loaded !== 10'd0) $display("FAIL %s words_loaded got=%0h exp=0", tag, words_loaded); else passes++;
    total++; if ({cycle_ovf, cycle_count} !== 17'd0) $display("FAIL %s cycle got=%0h exp=0", tag, {cycle_ovf, cycle_count}); else passes++;
  endtask

  task automatic send(input logic [8:0] d, input logic last, input int gap);
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 9'($urandom);
      in_last  = 1'($urandom);
      halt     = 1'($urandom);
      tick();
      total++; if (im_we !== 1'b0) $display("FAIL gap_we got=%0h exp=0", im_we); else passes++;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    halt     = 1'($urandom);
    total++; if (in_ready !== 1'b1) $display("FAIL load_ready got=%0h exp=1", in_ready); else passes++;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    halt     = 1'b0;
  endtask

  // Loads the words in prog; on return the block is in its first RUN cycle.
  task automatic load_prog(input int gap_lo, input int gap_hi);
    int n;
    n = prog.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    cap.delete();
    total++; if ({words_loaded, cycle_count, cycle_ovf} !== 27'd0) $display("FAIL start_clear got=%0h exp=0", {words_loaded, cycle_count, cycle_ovf}); else passes++;
    total++; if ({busy, done, in_ready} !== 3'b101) $display("FAIL start_status got=%0b exp=101", {busy, done, in_ready}); else passes++;
    for (int i = 0; i < n; i++)
      send(prog[i], (i == n - 1), $urandom_range(gap_hi, gap_lo));
    total++; if ({im_we, in_ready, core_reset, busy} !== 4'b1011) $display("FAIL flush_status got=%0b exp=1011", {im_we, in_ready, core_reset, busy}); else passes++;
    tick();
    total++; if ({core_reset, im_we, busy} !== 3'b001) $display("FAIL run_status got=%0b exp=001", {core_reset, im_we, busy}); else passes++;
    total++; if (words_loaded !== 10'(n)) $display("FAIL words_loaded got=%0d exp=%0d", words_loaded, n); else passes++;
    total++; if (cap.size() !== n) $display("FAIL write_count got=%0d exp=%0d", cap.size(), n); else passes++;
    for (int i = 0; i < n && i < cap.size(); i++) begin
      total++; if (cap[i] !== {9'(i), prog[i]}) $display("FAIL write_%0d got=%0h exp=%0h", i, cap[i], {9'(i), prog[i]}); else passes++;
    end
  endtask

  // Runs n halt-free cycles, then halts; optional stray start pulses.
  task automatic run_prog(input int n, input logic poke_start);
    halt = 1'b0;
    for (int i = 0; i < n; i++) begin
      start = poke_start ? 1'($urandom) : 1'b0;
      tick();
    end
    start = 1'b0;
    total++; if ({busy, done, core_reset} !== 3'b100) $display("FAIL pre_halt got=%0b exp=100", {busy, done, core_reset}); else passes++;
    total++; if (cycle_count !== 16'(n)) $display("FAIL run_count got=%0d exp=%0d", cycle_count, n); else passes++;
    halt = 1'b1;
    tick();
    halt = 1'($urandom);
    tick();
    halt = 1'b0;
    total++; if ({busy, done, core_reset} !== 3'b011) $display("FAIL done_status got=%0b exp=011", {busy, done, core_reset}); else passes++;
    total++; if ({cycle_ovf, cycle_count} !== {1'b0, 16'(n)}) $display("FAIL done_count got=%0d exp=%0d", cycle_count, n); else passes++;
    total++; if (words_loaded !== 10'(prog.size())) $display("FAIL done_words got=%0d exp=%0d", words_loaded, prog.size()); else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    check_idle_values("reset");
    reset = 1'b0;
    tick();
    check_idle_values("idle");
    prog.delete();
    prog.push_back(9'h123);
    load_prog(0, 0);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check_idle_values("reset_in_run");
    reset = 1'b0;
    tick();
  endtask

  task automatic test_load_basic();
    prog.delete();
    prog.push_back(9'h041);
    prog.push_back(9'h0A2);
    prog.push_back(9'h1FF);
    load_prog(0, 0);
    run_prog(10, 1'b0);
  endtask

  task automatic test_backpressure();
    prog.delete();
    for (int i = 0; i < 5; i++) prog.push_back(9'($urandom));
    load_prog(4, 4);
    run_prog($urandom_range(30, 1), 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      prog.delete();
      for (int i = 0; i < $urandom_range(12, 1); i++) prog.push_back(9'($urandom));
      load_prog(0, 1);
      run_prog($urandom_range(40, 0), 1'b0);
    end
  endtask

  task automatic test_reset_mid_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    send(9'h0AA, 1'b0, 0);
    send(9'h055, 1'b0, 1);
    #2;
    reset = 1'b1;
    #1;
    check_idle_values("reset_in_load");
    reset = 1'b0;
    tick();
    prog.delete();
    for (int i = 0; i < 4; i++) prog.push_back(9'($urandom));
    load_prog(0, 2);
    run_prog($urandom_range(25, 5), 1'b1);
  endtask

  task automatic test_full_small();
    logic [8:0] words[$];
    int n_run, exp_cnt;
    logic exp_ovf;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    s_cap.delete();
    for (int i = 0; i < 8; i++) begin
      words.push_back(9'($urandom));
      s_in_valid = 1'b1;
      s_in_data  = words[i];
      s_in_last  = 1'b0;
      tick();
      s_in_valid = 1'b0;
    end
    total++; if ({s_in_ready, s_im_we, s_busy} !== 3'b011) $display("FAIL full_flush got=%0b exp=011", {s_in_ready, s_im_we, s_busy}); else passes++;
    s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
    total++; if ({s_core_reset, s_im_we} !== 2'b00) $display("FAIL full_run got=%0b exp=00", {s_core_reset, s_im_we}); else passes++;
    total++; if (s_words_loaded !== 4'd8) $display("FAIL full_words got=%0d exp=8", s_words_loaded); else passes++;
    total++; if (s_cap.size() !== 8) $display("FAIL full_writes got=%0d exp=8", s_cap.size()); else passes++;
    for (int i = 0; i < 8 && i < s_cap.size(); i++) begin
      total++; if (s_cap[i] !== {3'(i), words[i]}) $display("FAIL full_write_%0d got=%0h exp=%0h", i, s_cap[i], {3'(i), words[i]}); else passes++;
    end
    n_run = 20;
    s_halt = 1'b0;
    repeat (n_run) tick();
    s_halt = 1'b1;
    tick();
    s_halt = 1'b0;
    exp_cnt = (n_run > 15) ? 15 : n_run;
    exp_ovf = (n_run > 15);
    total++; if (s_cycle_count !== 4'(exp_cnt)) $display("FAIL sat_count got=%0d exp=%0d", s_cycle_count, exp_cnt); else passes++;
    total++; if (s_cycle_ovf !== exp_ovf) $display("FAIL sat_ovf got=%0b exp=%0b", s_cycle_ovf, exp_ovf); else passes++;
    total++; if ({s_done, s_core_reset} !== 2'b11) $display("FAIL sat_done got=%0b exp=11", {s_done, s_core_reset}); else passes++;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    halt = 1'b0; in_data = '0;
    s_reset = 1'b0; s_start = 1'b0; s_in_valid = 1'b0; s_in_last = 1'b0;
    s_halt = 1'b0; s_in_data = '0;
    #1;
    s_reset = 1'b1;
    test_reset();
    s_reset = 1'b0;
    test_load_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_load();
    test_full_small();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
